// File: rtl/deck_shuffler_if.sv
// deck_shuffler_if: handshake bundle between the game controller (master)
// and the deck store (slave).
// DECK_SEED_PORT_EN adds a 16-bit shuffle seed driven by the controller.
interface deck_shuffler_if #(
  parameter int CARD_W = 6,
  parameter int IDX_W  = 7
);
  logic              clear;
  logic              wr_valid;
  logic [CARD_W-1:0] wr_card;
  logic              wr_ready;
  logic              start;
  logic              busy;
  logic [CARD_W-1:0] card;
  logic              card_valid;
  logic              card_ready;
  logic [IDX_W:0]    remaining;
  logic              empty;
`ifdef DECK_SEED_PORT_EN
  logic [15:0]       seed;

  modport master (
    output clear, wr_valid, wr_card, start, card_ready, seed,
    input  wr_ready, busy, card, card_valid, remaining, empty
  );

  modport slave (
    input  clear, wr_valid, wr_card, start, card_ready, seed,
    output wr_ready, busy, card, card_valid, remaining, empty
  );
`else
  modport master (
    output clear, wr_valid, wr_card, start, card_ready,
    input  wr_ready, busy, card, card_valid, remaining, empty
  );

  modport slave (
    input  clear, wr_valid, wr_card, start, card_ready,
    output wr_ready, busy, card, card_valid, remaining, empty
  );
`endif
endinterface

// File: rtl/deck_shuffler.sv
// deck_shuffler: card-deck store with in-place Fisher-Yates shuffle.
// Cards are appended at deck[count], dealt from deck[count-1].
// The shuffle walks end_idx from count-1 down to 1, drawing a candidate
// index from a 16-bit Galois LFSR (mask 16'hB400) and rejecting any
// candidate above end_idx, so each accepted draw is a valid swap partner.
// Seed comes from a free-running counter, or from the bus seed input when
// DECK_SEED_PORT_EN is defined (zero seed maps to 16'h0001).
//
// state   | meaning
// IDLE    | after reset or clear, accepting appends
// SHUFFLE | swap loop in progress, deck locked
// DEAL    | top card offered, appends still accepted
module deck_shuffler #(
  parameter int N_CARDS = 108,
  parameter int CARD_W  = 6,
  parameter int IDX_W   = $clog2(N_CARDS)
) (
  input logic            i_clk,
  input logic            i_rst_n,
  deck_shuffler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHUFFLE, DEAL} state_t;

  localparam logic [IDX_W:0]   FULL    = (IDX_W+1)'(N_CARDS);
  localparam logic [IDX_W:0]   CNT_ONE = (IDX_W+1)'(1);
  localparam logic [IDX_W:0]   CNT_TWO = (IDX_W+1)'(2);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  state_t            state;
  logic [IDX_W:0]    count;
  logic [15:0]       lfsr;
  logic [15:0]       free_cnt;
  logic [IDX_W-1:0]  end_idx;
  logic [CARD_W-1:0] deck [N_CARDS];

  logic [15:0]       lfsr_nxt;
  logic [15:0]       seed_src;
  logic [15:0]       seed_val;
  logic [IDX_W-1:0]  cand;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W:0]    count_nxt;
  logic              wr_ready;
  logic              card_valid;
  logic              push;
  logic              pop;
  logic              swap;

  // Datapath decode: LFSR step, swap accept, append/pop bookkeeping.
  always_comb begin
    lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    cand     = lfsr_nxt[IDX_W-1:0];
    swap     = (state == SHUFFLE) && (cand <= end_idx);
`ifdef DECK_SEED_PORT_EN
    seed_src = bus.seed;
`else
    seed_src = free_cnt;
`endif
    seed_val   = (seed_src == 16'h0000) ? 16'h0001 : seed_src;
    wr_ready   = (state != SHUFFLE) && (count < FULL);
    card_valid = (state == DEAL) && (count != '0);
    push       = bus.wr_valid && wr_ready;
    pop        = card_valid && bus.card_ready;
    top_idx    = IDX_W'(count - CNT_ONE);
    // A same-cycle pop frees the top slot, so the new card lands there.
    wr_idx     = pop ? top_idx : IDX_W'(count);
    if (push && pop)
      count_nxt = count;
    else if (push)
      count_nxt = count + CNT_ONE;
    else if (pop)
      count_nxt = count - CNT_ONE;
    else
      count_nxt = count;
  end

  // Control FSM: sequencing, deck count, seed and shuffle index.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      count    <= '0;
      lfsr     <= 16'h0001;
      free_cnt <= 16'h0000;
      end_idx  <= '0;
    end else begin
      free_cnt <= free_cnt + 16'd1;
      if (bus.clear) begin
        count <= '0;
        state <= IDLE;
      end else begin
        case (state)
          IDLE, DEAL: begin
            count <= count_nxt;
            if (bus.start) begin
              lfsr    <= seed_val;
              end_idx <= IDX_W'(count_nxt - CNT_ONE);
              state   <= (count_nxt >= CNT_TWO) ? SHUFFLE : DEAL;
            end
          end
          SHUFFLE: begin
            lfsr <= lfsr_nxt;
            if (swap) begin
              end_idx <= end_idx - IDX_ONE;
              if (end_idx == IDX_ONE)
                state <= DEAL;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Deck storage: shuffle swaps and appends never overlap (no appends in SHUFFLE).
  always_ff @(posedge i_clk) begin
    if (!bus.clear) begin
      if (swap) begin
        deck[end_idx] <= deck[cand];
        deck[cand]    <= deck[end_idx];
      end else if (push) begin
        deck[wr_idx] <= bus.wr_card;
      end
    end
  end

  assign bus.wr_ready   = wr_ready;
  assign bus.busy       = (state == SHUFFLE);
  assign bus.card_valid = card_valid;
  assign bus.card       = card_valid ? deck[top_idx] : '0;
  assign bus.remaining  = count;
  assign bus.empty      = (count == '0);

endmodule

// File: tb/tb_deck_shuffler.sv
// tb_deck_shuffler: randomized bench with a reference deck model.
// The model keeps the deck as an integer array and applies the shuffle
// rules with plain arithmetic; expected deal order and shuffle length come
// from it. Seeded-replay checks run when DECK_SEED_PORT_EN is defined.
`timescale 1ns/1ps
module tb_deck_shuffler;
  localparam int N   = 108;
  localparam int CW  = 6;
  localparam int IW  = 7;
  localparam int MOD = 1 << IW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  deck_shuffler_if #(.CARD_W(CW), .IDX_W(IW)) bus();

  deck_shuffler #(.N_CARDS(N), .CARD_W(CW), .IDX_W(IW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference free-running cycle counter (seed source when no seed port).
  logic [15:0] ref_cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ref_cyc <= 16'h0000;
    else        ref_cyc <= ref_cyc + 16'd1;

  int m_deck [N];
  int m_cnt   = 0;
  int m_state = 0;   // 0 idle, 1 shuffling, 2 dealing
  int seq_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] seed_now();
`ifdef DECK_SEED_PORT_EN
    return bus.seed;
`else
    return ref_cyc;
`endif
  endfunction

  // Fisher-Yates with rejection on the model array; returns the LFSR step count.
  task automatic model_shuffle(input logic [15:0] seed, output int steps);
    int l, e, c, t;
    l = (seed == 16'h0000) ? 1 : int'(seed);
    e = m_cnt - 1;
    steps = 0;
    while (e > 0 && steps < 100000) begin
      if (l % 2 == 1) l = (l / 2) ^ 'hB400;
      else            l = l / 2;
      steps++;
      c = l % MOD;
      if (c <= e) begin
        t = m_deck[e]; m_deck[e] = m_deck[c]; m_deck[c] = t;
        e--;
      end
    end
  endtask

  task automatic wait_shuffle(input int steps);
    int n;
    n = 0;
    check("shuffle_wr_ready", bus.wr_ready, 0);
    check("shuffle_valid", bus.card_valid, 0);
    while (bus.busy === 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check("shuffle_cycles", n, steps);
  endtask

  // One bus cycle: check outputs against the model, drive, advance the model.
  task automatic step(input bit psh, input logic [CW-1:0] c, input bit pp, input bit st);
    bit exp_ready, exp_valid;
    logic [15:0] sd;
    int steps;
    exp_ready = (m_state != 1) && (m_cnt < N);
    exp_valid = (m_state == 2) && (m_cnt > 0);
    check("remaining", bus.remaining, m_cnt);
    check("empty", bus.empty, (m_cnt == 0));
    check("wr_ready", bus.wr_ready, exp_ready);
    check("card_valid", bus.card_valid, exp_valid);
    check("busy", bus.busy, 0);
    if (exp_valid) check("card", bus.card, m_deck[m_cnt-1]);
    if (pp && exp_valid) seq_q.push_back(int'(bus.card));
    bus.wr_valid   = psh;
    bus.wr_card    = c;
    bus.card_ready = pp;
    bus.start      = st;
    sd = seed_now();
    @(negedge clk);
    bus.wr_valid   = 1'b0;
    bus.card_ready = 1'b0;
    bus.start      = 1'b0;
    if (psh && exp_ready && pp && exp_valid) m_deck[m_cnt-1] = int'(c);
    else if (pp && exp_valid) m_cnt--;
    else if (psh && exp_ready) begin m_deck[m_cnt] = int'(c); m_cnt++; end
    if (st) begin
      if (m_cnt >= 2) begin
        m_state = 1;
        model_shuffle(sd, steps);
        wait_shuffle(steps);
      end
      m_state = 2;
    end
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    m_cnt = 0;
    m_state = 0;
  endtask

  task automatic load_full();
    for (int i = 0; i < N; i++) step(1'b1, CW'(i % 64), 1'b0, 1'b0);
  endtask

  task automatic check_idle_empty(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_remaining"}, bus.remaining, 0);
    check({tag, "_empty"}, bus.empty, 1);
    check({tag, "_wr_ready"}, bus.wr_ready, 1);
    check({tag, "_valid"}, bus.card_valid, 0);
  endtask

`ifdef DECK_SEED_PORT_EN
  task automatic run_seeded(input logic [15:0] s, output int seq [N]);
    do_clear();
    load_full();
    bus.seed = s;
    step(1'b0, '0, 1'b0, 1'b1);
    seq_q.delete();
    for (int i = 0; i < N; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("seeded_empty", bus.empty, 1);
    for (int i = 0; i < N; i++) seq[i] = (i < seq_q.size()) ? seq_q[i] : -1;
  endtask
`endif

  initial begin
    bus.clear = 1'b0; bus.wr_valid = 1'b0; bus.wr_card = '0;
    bus.start = 1'b0; bus.card_ready = 1'b0;
`ifdef DECK_SEED_PORT_EN
    bus.seed = 16'h0000;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state.
    check_idle_empty("reset");
    check("reset_card", bus.card, 0);

    // Fill to capacity, then an ignored extra write.
    load_full();
    check("full_remaining", bus.remaining, N);
    check("full_wr_ready", bus.wr_ready, 0);
    step(1'b1, 6'h15, 1'b0, 1'b0);
    check("overflow_remaining", bus.remaining, N);

    // Shuffle and deal everything; multiset must match the loaded set.
    step(1'b0, '0, 1'b0, 1'b1);
    seq_q.delete();
    for (int i = 0; i < N; i++) step(1'b0, '0, 1'b1, 1'b0);
    begin
      int hist [64];
      int bad;
      bad = 0;
      for (int v = 0; v < 64; v++) hist[v] = 0;
      foreach (seq_q[i]) hist[seq_q[i] % 64]++;
      for (int v = 0; v < 64; v++) if (hist[v] != ((v < N - 64) ? 2 : 1)) bad++;
      check("multiset_bins_off", bad, 0);
      check("dealt_count", seq_q.size(), N);
    end
    check("deal_all_empty", bus.empty, 1);

`ifdef DECK_SEED_PORT_EN
    begin
      int sa [N], sb [N], sc [N];
      int same_ab, diff_ac;
      run_seeded(16'hACE1, sa);
      run_seeded(16'hACE1, sb);
      run_seeded(16'h1234, sc);
      same_ab = 1; diff_ac = 0;
      for (int i = 0; i < N; i++) begin
        if (sa[i] != sb[i]) same_ab = 0;
        if (sa[i] != sc[i]) diff_ac = 1;
      end
      check("seed_replay_same", same_ab, 1);
      check("seed_change_differs", diff_ac, 1);
    end
`endif

    // Single card: straight to DEAL, no shuffle cycles.
    do_clear();
    step(1'b1, 6'h2A, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    check("single_busy", bus.busy, 0);
    check("single_valid", bus.card_valid, 1);
    check("single_card", bus.card, 6'h2A);
    step(1'b0, '0, 1'b1, 1'b0);
    check("single_empty", bus.empty, 1);

    // Partial deal, pop+append, append, reshuffle.
    load_full();
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("pop10_remaining", bus.remaining, 98);
    step(1'b1, 6'h3F, 1'b1, 1'b0);
    check("popappend_remaining", bus.remaining, 98);
    for (int i = 0; i < 3; i++) step(1'b1, CW'($urandom_range(0, 63)), 1'b0, 1'b0);
    check("append3_remaining", bus.remaining, 101);
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 101; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("reshuffle_empty", bus.empty, 1);

    // Clear in the middle of a shuffle.
    do_clear();
    load_full();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", bus.busy, 1);
    do_clear();
    check_idle_empty("clear_mid");

    // Async reset in the middle of a shuffle.
    for (int i = 0; i < 20; i++) step(1'b1, CW'($urandom_range(0, 63)), 1'b0, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid2_busy", bus.busy, 1);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    m_cnt = 0;
    m_state = 0;
    @(negedge clk);
    check_idle_empty("rst_mid");

    // Randomized mix of appends, pops, shuffles and clears.
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r <= 6)       step(1'b1, CW'($urandom_range(0, 63)), 1'b0, 1'b0);
      else if (r <= 11) step(1'b0, '0, 1'b1, 1'b0);
      else if (r <= 15) step(1'b1, CW'($urandom_range(0, 63)), 1'b1, 1'b0);
      else if (r == 16) step(1'b0, '0, 1'b0, 1'b1);
      else if (r <= 18) step(1'b0, '0, 1'b0, 1'b0);
      else              do_clear();
    end
    step(1'b0, '0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
